// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Types and helpers shared by the decode stage, execute and the hazard logic:
//   instr_packet     raw 32-bit RV32 instruction word
//   queue_entry_t    {pc, instr} record buffered by decode_queue
//   decode_bundle_t  registered control bundle handed to execute
//   uses_rs1/uses_rs2  opcode-keyed source-register usage lookup
//   alu_from_f3, imm_gen  per-unit decode helpers
// ---------------------------------------------------------------------------
package decode_stage_pkg;

   localparam int unsigned PC_W = 32;

   typedef logic [31:0] instr_packet;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU, WB_MEM, WB_PC4, WB_CSR
   } wb_sel_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rd_we;
      imm_type_e       imm_type;
      logic [31:0]     imm;
      alu_op_e         alu_op;
      logic            alu_src_pc;
      logic            alu_src_imm;
      logic            br_en;
      logic [2:0]      br_funct3;
      logic            jump;
      wb_sel_e         wb_sel;
      logic            mem_re;
      logic            mem_we;
      logic [2:0]      mem_funct3;
      logic            csr_en;
      logic [1:0]      csr_op;
      logic [11:0]     csr_addr;
      logic            illegal;
   } decode_bundle_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      instr_packet     instr;
   } queue_entry_t;

   function automatic logic uses_rs1(input logic [6:0] opc);
      case (opc)
         OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
         OPC_OPIMM, OPC_OP, OPC_SYSTEM: uses_rs1 = 1'b1;
         default:                       uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      case (opc)
         OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
         default:                       uses_rs2 = 1'b0;
      endcase
   endfunction

   // alt selects SUB/SRA (instr[30]); callers only set it where it is meaningful
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_f3 = ALU_SLL;
         3'b010:  alu_from_f3 = ALU_SLT;
         3'b011:  alu_from_f3 = ALU_SLTU;
         3'b100:  alu_from_f3 = ALU_XOR;
         3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_from_f3 = ALU_OR;
         default: alu_from_f3 = ALU_AND;
      endcase
   endfunction

   function automatic logic [31:0] imm_gen(input imm_type_e t, input instr_packet i);
      case (t)
         IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
         IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   imm_gen = {i[31:12], 12'b0};
         IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: imm_gen = '0;
      endcase
   endfunction

endpackage

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Circular buffer of DEPTH entries of type T (DEPTH a power of two, >= 2).
// Ports:
//   clock, reset        core clock, asynchronous active-high reset
//   push_i, push_data_i write an entry (ignored when full or flushing)
//   pop_i               retire the head (ignored when empty or flushing)
//   flush_i             empty the buffer at the next edge
//   head_o              entry at the read pointer
//   count_o             number of valid entries (0..DEPTH)
//   full_o, empty_o     derived from the registered count
// ---------------------------------------------------------------------------
module decode_queue #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [31:0]
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  T                       push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output T                       head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW:0]    count_q, count_d;
   logic           do_push, do_pop;

   // Count is kept apart from the pointers so full and empty never alias
   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: an entry only counts once count_q covers it
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Buffers fetched instructions in decode_queue and decodes the queue head into
// a registered decode_bundle_t for execute, with a load-use interlock.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag illegal encodings and
// suppress their side effects; when undefined they decode as NOPs).
// Ports:
//   clock, reset           core clock, asynchronous active-high reset
//   in_valid/in_ready      fetch handshake; in_ready = queue not full
//   in_instr, in_pc        fetched instruction and its PC
//   out_valid/out_ready    execute handshake
//   out_bundle             registered decoded control bundle
//   flush                  drop queued and output-slot instructions
//   ex_load_valid/_rd      load currently in execute and its destination
//   occupancy              queued entries, output slot excluded
// ---------------------------------------------------------------------------
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  instr_packet            in_instr,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output decode_bundle_t         out_bundle,
   input  logic                   flush,
   input  logic                   ex_load_valid,
   input  logic [4:0]             ex_load_rd,
   output logic [$clog2(DEPTH):0] occupancy
);

   queue_entry_t    push_entry, head;
   logic            q_full, q_empty;
   logic            hazard, advance;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            known, bad_fn;
   decode_bundle_t  dec;
   decode_bundle_t  out_bundle_q, out_bundle_d;
   logic            out_valid_q, out_valid_d;

   assign push_entry.pc    = PC_W'(in_pc);
   assign push_entry.instr = in_instr;

   decode_queue #(
      .DEPTH (DEPTH),
      .T     (queue_entry_t)
   ) u_queue (
      .clock       (clock),
      .reset       (reset),
      .push_i      (in_valid),
      .push_data_i (push_entry),
      .pop_i       (advance),
      .flush_i     (flush),
      .head_o      (head),
      .count_o     (occupancy),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

   assign in_ready = !q_full;

   assign opc = head.instr[6:0];
   assign f3  = head.instr[14:12];
   assign f7  = head.instr[31:25];

   // Head decode
   always_comb begin
      dec        = '0;
      known      = 1'b1;
      bad_fn     = 1'b0;
      dec.pc     = head.pc;
      dec.rs1    = head.instr[19:15];
      dec.rs2    = head.instr[24:20];
      dec.rd     = head.instr[11:7];
      case (opc)
         OPC_LUI: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_U; dec.alu_op = ALU_PASSB;
            dec.alu_src_imm = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_U;
            dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_JAL: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_J; dec.jump = 1'b1;
            dec.wb_sel = WB_PC4; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_JALR: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_I; dec.jump = 1'b1;
            dec.wb_sel = WB_PC4; dec.alu_src_imm = 1'b1;
            bad_fn = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.imm_type = IMM_B; dec.br_en = 1'b1; dec.br_funct3 = f3;
            bad_fn = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_I; dec.mem_re = 1'b1;
            dec.mem_funct3 = f3; dec.wb_sel = WB_MEM; dec.alu_src_imm = 1'b1;
            bad_fn = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec.imm_type = IMM_S; dec.mem_we = 1'b1; dec.mem_funct3 = f3;
            dec.alu_src_imm = 1'b1;
            bad_fn = (f3 > 3'b010);
         end
         OPC_OPIMM: begin
            dec.rd_we = 1'b1; dec.imm_type = IMM_I; dec.alu_src_imm = 1'b1;
            dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
            bad_fn = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                     ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
         end
         OPC_OP: begin
            dec.rd_we  = 1'b1;
            dec.alu_op = alu_from_f3(f3, f7[5]);
            bad_fn = !((f7 == 7'h00) ||
                       ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_FENCE: ;
         OPC_SYSTEM: begin
            // funct3==0 (ecall/ebreak) is passed on as a plain NOP
            if (f3 != 3'b000) begin
               dec.csr_en = 1'b1; dec.csr_op = f3[1:0];
               dec.csr_addr = head.instr[31:20]; dec.rd_we = 1'b1;
               dec.wb_sel = WB_CSR;
            end
            bad_fn = (f3 == 3'b100);
         end
         default: known = 1'b0;
      endcase
      dec.imm = imm_gen(dec.imm_type, head.instr);
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!known || bad_fn) begin
         dec.illegal = 1'b1;
         dec.rd_we   = 1'b0;
         dec.mem_re  = 1'b0;
         dec.mem_we  = 1'b0;
         dec.csr_en  = 1'b0;
      end
`else
      // Unrecognised encodings fall back to NOP control, keeping pc/reg fields
      if (!known || bad_fn) begin
         dec     = '0;
         dec.pc  = head.pc;
         dec.rs1 = head.instr[19:15];
         dec.rs2 = head.instr[24:20];
         dec.rd  = head.instr[11:7];
      end
`endif
      if (dec.rd == 5'd0) dec.rd_we = 1'b0;
   end

   // Load-use interlock on the head, against this cycle's execute load
   assign hazard  = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((uses_rs1(opc) && (head.instr[19:15] == ex_load_rd)) ||
                     (uses_rs2(opc) && (head.instr[24:20] == ex_load_rd)));
   assign advance = !q_empty && (!out_valid_q || out_ready) && !hazard;

   // Output register: flush wins, then advance; a consumed or stalled slot
   // drops valid (bubble), otherwise the bundle is held bit-for-bit
   always_comb begin
      out_valid_d  = out_valid_q;
      out_bundle_d = out_bundle_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (advance) begin
         out_valid_d  = 1'b1;
         out_bundle_d = dec;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_bundle_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_bundle_q <= out_bundle_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_bundle = out_bundle_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined successor to the single-cycle decoder: buffers fetched instructions in a parametrised queue and decodes the queue head into a registered control bundle for the execute stage. Adds valid/ready handshakes on both sides, pipeline flush and a load-use interlock. Sits between fetch and execute in the pipelined RV32 core and reuses the existing per-unit decode helpers unchanged.

## Interface
- DEPTH, 4: instruction queue entries; power of two, ≥2.
- XLEN, 32: PC width.
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue not full; a transfer occurs on in_valid && in_ready.
- in_instr  in  instr_packet  fetched instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  out_bundle holds a decoded instruction.
- out_ready  in  1  execute accepts out_bundle.
- out_bundle  out  decode_bundle_t  pc, reg-file read/write params, imm_type, exec params, branch-compare params, write-back select, mem params, csr params, illegal flag.
- flush  in  1  discard all queued and output-slot instructions.
- ex_load_valid  in  1  execute holds a load.
- ex_load_rd  in  5  destination of that load.
- occupancy  out  $clog2(DEPTH)+1  queued entries, excluding the output slot.

## Operation
- Queue: circular buffer of {pc, instr}. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- in_ready = (count != DEPTH). It is combinational from registered state only and never depends on in_valid.
- Head decode is combinational, using the existing decode helpers on the head entry.
- Advance condition: queue not empty, AND the output slot is empty or out_ready=1, AND there is no hazard.
  - On advance: the output register loads the decoded head, out_valid=1, and the read pointer increments.
- Hazard: ex_load_valid && ex_load_rd != 0 && ((head uses rs1 && rs1 == ex_load_rd) || (head uses rs2 && rs2 == ex_load_rd)).
  - During a hazard the head is held.
  - If out_ready=1, out_valid drops to 0 (a bubble is emitted).
- Output hold: while out_valid && !out_ready, out_bundle stays stable bit-for-bit.
- Simultaneous push and pop on a full queue: the pop frees the slot, but in_ready was 0, so no push occurs. Full throughput is one instruction per cycle when the queue is neither full nor empty.
- Flush:
  - On the edge where flush=1: count←0, both pointers←0, out_valid←0.
  - A push presented in the same cycle is dropped.
  - Flush overrides advance and hazard.
- Reset: the same effect as flush, applied asynchronously. Every out_bundle field resets to 0. Reset mid-transfer loses the instruction; no partial entry survives.
- rd write enable is forced to 0 when rd == x0.

## Timing
- Reset values:
  - in_ready=1 (queue empty).
  - out_valid=0, out_bundle=0, occupancy=0.
- Latency: an instruction accepted at edge k appears on out_valid after edge k+1, if there is no hazard and the output slot is free. Minimum latency is 2 clocks from in_valid to out_valid.
- The output bundle is registered. No combinational path runs from in_* to out_*.
- in_ready and occupancy update one edge after the transfer.
- The hazard check uses the current-cycle ex_load_*. The decision is registered at the same edge as the advance.

## Configuration
- DECODE_ILLEGAL_TRAP_EN:
  - Defined: unknown opcode, or an unsupported funct3/funct7 combination, sets out_bundle.illegal=1. Write enable, mem and csr enables are forced to 0 for that instruction. The instruction still occupies one slot and flows normally.
  - Undefined: illegal is tied to 0, and unknown encodings decode to the helpers' default (NOP) params.

## Structure
- decode_stage_pkg holds:
  - decode_bundle_t
  - queue_entry_t
  - the uses_rs1/uses_rs2 lookup function keyed on opcode
- These live in the package so execute and hazard logic share them.
- Sub-module decode_queue is the circular buffer: push/pop/flush, count, head. It is parametrised by DEPTH and entry type.
- decode_stage instantiates decode_queue, the existing decode helper modules, the hazard compare and the output register.

## Test plan
- Reset, then stream 8 ADDI (pc 0x0..0x1C) with out_ready=1 → out_valid rises 2 clocks after the first push; then one bundle per cycle; PCs in order.
- Hold out_ready=0 and push 6 with DEPTH=4 → occupancy reaches 4, in_ready=0, out_bundle stays stable; release → all 5 delivered in order, none lost.
- Head is `add x3,x5,x6` with ex_load_valid=1, ex_load_rd=5 for 2 cycles → 2 bubbles (out_valid=0), then the add is issued. Repeat with ex_load_rd=0 → no stall.
- Push 3, assert flush together with a 4th push → next cycle occupancy=0, out_valid=0; the 4th is dropped; next push pc 0x100 is emitted first.
- Assert reset mid-stream with 2 queued → outputs zero immediately, asynchronously; after release in_ready=1 and occupancy=0.
- With DECODE_ILLEGAL_TRAP_EN, push 0xFFFFFFFF → illegal=1, rd write and mem enables=0; without the macro → illegal=0.
